// File: rtl/ip_tx_arbiter.sv
// Round-robin arbiter sharing the IP transmit send port between UDP transmit and ICMP reply.
// One frame per grant; the next grant waits for the IP layer's end of frame plus an idle gap.
module ip_tx_arbiter #(
  parameter int P_GAP_CYCLES    = 8,
  parameter int P_GRANT_TIMEOUT = 64,
  parameter int P_DONE_TIMEOUT  = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_udp_req,
  input  logic [15:0] i_udp_len,
  input  logic [7:0]  i_udp_data,
  input  logic        i_udp_last,
  input  logic        i_udp_valid,
  output logic        o_udp_grant,
  input  logic        i_icmp_req,
  input  logic [15:0] i_icmp_len,
  input  logic [7:0]  i_icmp_data,
  input  logic        i_icmp_last,
  input  logic        i_icmp_valid,
  output logic        o_icmp_grant,
  output logic [7:0]  o_send_data,
  output logic [7:0]  o_send_type,
  output logic [15:0] o_send_len,
  output logic        o_send_last,
  output logic        o_send_valid,
  input  logic        i_mac_last,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [7:0]  TYPE_UDP   = 8'd17;
  localparam logic [7:0]  TYPE_ICMP  = 8'd1;
  localparam logic [15:0] GRANT_LAST = 16'(P_GRANT_TIMEOUT - 1);
  localparam logic [15:0] DONE_LAST  = 16'(P_DONE_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST   = 16'(P_GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_XFER,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;          // 0 = UDP, 1 = ICMP
  logic        last_icmp_q, last_icmp_d;  // last-served requester was ICMP
  logic        udp_grant_q, udp_grant_d;
  logic        icmp_grant_q, icmp_grant_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmr_q, tmr_d;
  logic [7:0]  send_data_q, send_data_d;
  logic        send_last_q, send_last_d;
  logic        send_valid_q, send_valid_d;
  logic        err_q, err_d;

  logic        own_valid, own_last, stray;
  logic [7:0]  own_data;
  logic [15:0] cnt_inc;
  logic        at_len, closing, frame_err;

  // A frame closes cleanly only when the owner's last flag and the byte count agree.
  function automatic logic len_mismatch(input logic last, input logic reached_len);
    return last != reached_len;
  endfunction

  always_comb begin
    own_valid = owner_q ? i_icmp_valid : i_udp_valid;
    own_last  = owner_q ? i_icmp_last  : i_udp_last;
    own_data  = owner_q ? i_icmp_data  : i_udp_data;
    // In IDLE nobody owns the port, so any byte is unsolicited; afterwards the
    // previous owner's trailing bytes are dropped silently.
    if (state_q == S_IDLE) stray = i_udp_valid | i_icmp_valid;
    else                   stray = owner_q ? i_udp_valid : i_icmp_valid;
    // 16-bit wrap makes a latched length of 0 close at byte 65536.
    cnt_inc = cnt_q + 16'd1;
    at_len  = (cnt_inc == len_q);
    closing = own_last | at_len;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_icmp_d  = last_icmp_q;
    udp_grant_d  = udp_grant_q;
    icmp_grant_d = icmp_grant_q;
    len_d        = len_q;
    type_d       = type_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    send_data_d  = send_data_q;
    send_last_d  = 1'b0;
    send_valid_d = 1'b0;
    frame_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_udp_req && (!i_icmp_req || last_icmp_q)) begin
          owner_d     = 1'b0;
          last_icmp_d = 1'b0;
          udp_grant_d = 1'b1;
          len_d       = i_udp_len;
          type_d      = TYPE_UDP;
          cnt_d       = '0;
          tmr_d       = '0;
          state_d     = S_GRANT;
        end else if (i_icmp_req) begin
          owner_d      = 1'b1;
          last_icmp_d  = 1'b1;
          icmp_grant_d = 1'b1;
          len_d        = i_icmp_len;
          type_d       = TYPE_ICMP;
          cnt_d        = '0;
          tmr_d        = '0;
          state_d      = S_GRANT;
        end
      end
      S_GRANT, S_XFER: begin
        if (own_valid) begin
          send_valid_d = 1'b1;
          send_data_d  = own_data;
          send_last_d  = closing;
          cnt_d        = cnt_inc;
          state_d      = S_XFER;
          if (closing) begin
            udp_grant_d  = 1'b0;
            icmp_grant_d = 1'b0;
            tmr_d        = '0;
            frame_err    = len_mismatch(own_last, at_len);
            state_d      = S_WAIT_DONE;
          end
        end else if (state_q == S_GRANT) begin
          if (tmr_q == GRANT_LAST) begin
            udp_grant_d  = 1'b0;
            icmp_grant_d = 1'b0;
            tmr_d        = '0;
            frame_err    = 1'b1;
            state_d      = S_GAP;
          end else begin
            tmr_d = tmr_q + 16'd1;
          end
        end
      end
      S_WAIT_DONE: begin
        if (i_mac_last) begin
          tmr_d   = '0;
          state_d = S_GAP;
        end else if (tmr_q == DONE_LAST) begin
          tmr_d     = '0;
          frame_err = 1'b1;
          state_d   = S_GAP;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    err_d = frame_err | stray;
  end

  // Registered boundary: arbitration state and the one-cycle output stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_icmp_q  <= 1'b1;
      udp_grant_q  <= 1'b0;
      icmp_grant_q <= 1'b0;
      len_q        <= '0;
      type_q       <= '0;
      cnt_q        <= '0;
      tmr_q        <= '0;
      send_data_q  <= '0;
      send_last_q  <= 1'b0;
      send_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_icmp_q  <= last_icmp_d;
      udp_grant_q  <= udp_grant_d;
      icmp_grant_q <= icmp_grant_d;
      len_q        <= len_d;
      type_q       <= type_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      send_data_q  <= send_data_d;
      send_last_q  <= send_last_d;
      send_valid_q <= send_valid_d;
      err_q        <= err_d;
    end
  end

  assign o_udp_grant  = udp_grant_q;
  assign o_icmp_grant = icmp_grant_q;
  assign o_send_data  = send_data_q;
  assign o_send_type  = type_q;
  assign o_send_len   = len_q;
  assign o_send_last  = send_last_q;
  assign o_send_valid = send_valid_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_err        = err_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter: expected send beats are queued by the stimulus
// and consumed by a monitor whenever the DUT presents a valid byte.
module tb_ip_tx_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_udp_req, i_udp_last, i_udp_valid;
  logic [15:0] i_udp_len;
  logic [7:0]  i_udp_data;
  logic        o_udp_grant;
  logic        i_icmp_req, i_icmp_last, i_icmp_valid;
  logic [15:0] i_icmp_len;
  logic [7:0]  i_icmp_data;
  logic        o_icmp_grant;
  logic [7:0]  o_send_data, o_send_type;
  logic [15:0] o_send_len;
  logic        o_send_last, o_send_valid;
  logic        i_mac_last;
  logic        o_busy, o_err;

  ip_tx_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_udp_req(i_udp_req), .i_udp_len(i_udp_len), .i_udp_data(i_udp_data),
    .i_udp_last(i_udp_last), .i_udp_valid(i_udp_valid), .o_udp_grant(o_udp_grant),
    .i_icmp_req(i_icmp_req), .i_icmp_len(i_icmp_len), .i_icmp_data(i_icmp_data),
    .i_icmp_last(i_icmp_last), .i_icmp_valid(i_icmp_valid), .o_icmp_grant(o_icmp_grant),
    .o_send_data(o_send_data), .o_send_type(o_send_type), .o_send_len(o_send_len),
    .o_send_last(o_send_last), .o_send_valid(o_send_valid),
    .i_mac_last(i_mac_last), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]  data;
    logic [7:0]  typ;
    logic [15:0] len;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int err_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Monitor: counts error pulses and checks every presented byte against the queue.
  always @(negedge i_clk) begin
    beat_t e;
    if (o_err === 1'b1) err_seen++;
    if (o_send_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0d, want no beat", o_send_data);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(o_send_data), 32'(e.data));
        chk("beat_type", 32'(o_send_type), 32'(e.typ));
        chk("beat_len",  32'(o_send_len),  32'(e.len));
        chk("beat_last", 32'(o_send_last), 32'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_grant(output int src, output int cyc);
    src = -1;
    cyc = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (o_udp_grant || o_icmp_grant) begin
        src = o_icmp_grant ? 1 : 0;
        cyc = i;
        break;
      end
    end
    if (src < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: got no grant in 300 cycles, want a grant");
    end else begin
      chk("grant_onehot", 32'(o_udp_grant & o_icmp_grant), 32'd0);
    end
  endtask

  task automatic set_req(input int src, input logic v, input logic [15:0] len);
    if (src == 0) begin i_udp_req = v; i_udp_len = len; end
    else begin i_icmp_req = v; i_icmp_len = len; end
  endtask

  // Drives nbytes from src (last flag on byte last_at, 0 = never); the first n_fwd
  // bytes are expected on the send port, the final one of those flagged last.
  task automatic send_bytes(input int src, input int nbytes, input int last_at,
                            input logic [7:0] base, input logic [15:0] len,
                            input int n_fwd, input int stray_at);
    beat_t b;
    logic [7:0] d;
    for (int i = 0; i < n_fwd; i++) begin
      d = base + 8'(i);
      b.data = d;
      b.typ  = (src == 0) ? 8'd17 : 8'd1;
      b.len  = len;
      b.last = (i == n_fwd - 1);
      exp_q.push_back(b);
    end
    for (int i = 0; i < nbytes; i++) begin
      d = base + 8'(i);
      if (src == 0) begin
        i_udp_valid = 1'b1; i_udp_data = d; i_udp_last = (i + 1 == last_at);
      end else begin
        i_icmp_valid = 1'b1; i_icmp_data = d; i_icmp_last = (i + 1 == last_at);
      end
      if (i == stray_at) begin
        if (src == 0) begin i_icmp_valid = 1'b1; i_icmp_data = 8'hEE; end
        else begin i_udp_valid = 1'b1; i_udp_data = 8'hEE; end
      end
      tick();
      if (src == 0) begin i_icmp_valid = 1'b0; end
      else begin i_udp_valid = 1'b0; end
    end
    i_udp_valid = 1'b0; i_udp_last = 1'b0;
    i_icmp_valid = 1'b0; i_icmp_last = 1'b0;
  endtask

  task automatic pulse_mac();
    i_mac_last = 1'b1;
    tick();
    i_mac_last = 1'b0;
  endtask

  task automatic close_out(input logic expect_idle);
    repeat (2) tick();
    pulse_mac();
    if (expect_idle) begin
      repeat (10) tick();
      chk("idle_after_gap", 32'(o_busy), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int src, cyc, e0, n;
    i_rst = 1'b1;
    i_udp_req = 0; i_udp_len = 0; i_udp_data = 0; i_udp_last = 0; i_udp_valid = 0;
    i_icmp_req = 0; i_icmp_len = 0; i_icmp_data = 0; i_icmp_last = 0; i_icmp_valid = 0;
    i_mac_last = 0;
    repeat (3) tick();
    chk("rst_udp_grant", 32'(o_udp_grant), 32'd0);
    chk("rst_icmp_grant", 32'(o_icmp_grant), 32'd0);
    chk("rst_send_valid", 32'(o_send_valid), 32'd0);
    chk("rst_send_type", 32'(o_send_type), 32'd0);
    chk("rst_send_len", 32'(o_send_len), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    i_rst = 1'b0;

    // UDP-only frame, then gap timing to the next grant
    set_req(0, 1'b1, 16'd10);
    wait_grant(src, cyc);
    chk("t1_src", 32'(src), 32'd0);
    chk("t1_req_to_grant", 32'(cyc), 32'd1);
    chk("t1_type", 32'(o_send_type), 32'd17);
    chk("t1_len", 32'(o_send_len), 32'd10);
    chk("t1_busy", 32'(o_busy), 32'd1);
    set_req(0, 1'b0, 16'd10);
    e0 = err_seen;
    send_bytes(0, 10, 10, 8'h00, 16'd10, 10, -1);
    chk("t1_grant_dropped", 32'(o_udp_grant), 32'd0);
    repeat (2) tick();
    pulse_mac();
    set_req(0, 1'b1, 16'd2);
    wait_grant(src, cyc);
    chk("t1_gap_to_grant", 32'(cyc), 32'd9);
    chk("t1_err", 32'(err_seen - e0), 32'd0);
    set_req(0, 1'b0, 16'd2);
    send_bytes(0, 2, 2, 8'h20, 16'd2, 2, -1);
    close_out(1'b1);

    // Simultaneous requests after reset alternate UDP, ICMP, ...
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    set_req(0, 1'b1, 16'd4);
    set_req(1, 1'b1, 16'd4);
    for (int k = 0; k < 4; k++) begin
      wait_grant(src, cyc);
      chk("t2_rr_src", 32'(src), 32'(k % 2));
      if (k > 0) chk("t2_rr_gap", 32'(cyc), 32'd9);
      if (k == 3) begin
        set_req(0, 1'b0, 16'd4);
        set_req(1, 1'b0, 16'd4);
      end
      send_bytes(src, 4, 4, 8'(8'h40 + 8'(k * 16)), 16'd4, 4, -1);
      close_out(k == 3);
    end

    // Length mismatches: early last, then count reaching len without last
    e0 = err_seen;
    set_req(0, 1'b1, 16'd8);
    wait_grant(src, cyc);
    set_req(0, 1'b0, 16'd8);
    send_bytes(0, 5, 5, 8'h80, 16'd8, 5, -1);
    chk("t3a_grant_dropped", 32'(o_udp_grant), 32'd0);
    close_out(1'b1);
    chk("t3a_err", 32'(err_seen - e0), 32'd1);
    e0 = err_seen;
    set_req(0, 1'b1, 16'd4);
    wait_grant(src, cyc);
    set_req(0, 1'b0, 16'd4);
    send_bytes(0, 6, 0, 8'h90, 16'd4, 4, -1);
    close_out(1'b1);
    chk("t3b_err", 32'(err_seen - e0), 32'd1);

    // Grant timeout with a UDP request pending
    set_req(1, 1'b1, 16'd3);
    wait_grant(src, cyc);
    chk("t4_src", 32'(src), 32'd1);
    set_req(1, 1'b0, 16'd3);
    set_req(0, 1'b1, 16'd2);
    e0 = err_seen;
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (!o_icmp_grant) begin n = i; break; end
    end
    chk("t4_timeout_cycles", 32'(n), 32'd64);
    wait_grant(src, cyc);
    chk("t4_next_src", 32'(src), 32'd0);
    chk("t4_next_cyc", 32'(cyc), 32'd9);
    chk("t4_err", 32'(err_seen - e0), 32'd1);
    set_req(0, 1'b0, 16'd2);
    send_bytes(0, 2, 2, 8'hA0, 16'd2, 2, -1);
    close_out(1'b1);

    // Stray non-owner byte mid-frame, then no mac_last (done timeout)
    set_req(0, 1'b1, 16'd6);
    wait_grant(src, cyc);
    set_req(0, 1'b0, 16'd6);
    e0 = err_seen;
    send_bytes(0, 6, 6, 8'hB0, 16'd6, 6, 2);
    repeat (4) tick();
    chk("t5_stray_err", 32'(err_seen - e0), 32'd1);
    e0 = err_seen;
    repeat (2040) tick();
    chk("t5_no_early_err", 32'(err_seen - e0), 32'd0);
    chk("t5_busy_waiting", 32'(o_busy), 32'd1);
    repeat (10) tick();
    chk("t5_done_err", 32'(err_seen - e0), 32'd1);
    repeat (10) tick();
    chk("t5_idle", 32'(o_busy), 32'd0);

    // Reset while byte 3 of 10 is presented
    set_req(0, 1'b1, 16'd10);
    wait_grant(src, cyc);
    set_req(0, 1'b0, 16'd10);
    exp_q.push_back('{data: 8'hC0, typ: 8'd17, len: 16'd10, last: 1'b0});
    exp_q.push_back('{data: 8'hC1, typ: 8'd17, len: 16'd10, last: 1'b0});
    i_udp_valid = 1'b1;
    i_udp_data = 8'hC0; tick();
    i_udp_data = 8'hC1; tick();
    i_udp_data = 8'hC2; i_rst = 1'b1; tick();
    chk("t6_grant", 32'(o_udp_grant | o_icmp_grant), 32'd0);
    chk("t6_valid", 32'(o_send_valid), 32'd0);
    chk("t6_last", 32'(o_send_last), 32'd0);
    chk("t6_data", 32'(o_send_data), 32'd0);
    chk("t6_type", 32'(o_send_type), 32'd0);
    chk("t6_len", 32'(o_send_len), 32'd0);
    chk("t6_busy", 32'(o_busy), 32'd0);
    i_rst = 1'b0;
    i_udp_valid = 1'b0;
    set_req(1, 1'b1, 16'd3);
    wait_grant(src, cyc);
    chk("t6_new_src", 32'(src), 32'd1);
    chk("t6_new_type", 32'(o_send_type), 32'd1);
    chk("t6_new_len", 32'(o_send_len), 32'd3);
    set_req(1, 1'b0, 16'd3);
    send_bytes(1, 3, 3, 8'hD0, 16'd3, 3, -1);
    close_out(1'b1);

    repeat (5) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_tx_arbiter.md
Name: ip_tx_arbiter

Overview:
- Shares the single IP transmit send port between two requesters: UDP transmit and ICMP reply.
- Grants one requester at a time using round-robin order.
- Forwards the granted payload stream with the correct IP protocol number and length.
- Holds off the next grant until the IP layer reports end of frame (mac last) plus a programmable inter-frame gap. This guarantees the IP transmitter sees one clean frame start per packet.

Parameters:
- P_GAP_CYCLES, 8: idle cycles enforced after i_mac_last before the next grant (valid range 1..255).
- P_GRANT_TIMEOUT, 64: cycles a granted requester may take to present its first byte before the grant is revoked.
- P_DONE_TIMEOUT, 2048: cycles to wait for i_mac_last after the payload ends before recovering to idle.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_udp_req  in  1  UDP requests the port (level; held until granted)
- i_udp_len  in  16  UDP payload byte count, sampled at grant
- i_udp_data  in  8  UDP payload byte
- i_udp_last  in  1  last UDP byte
- i_udp_valid  in  1  UDP byte valid
- o_udp_grant  out  1  UDP owns the port
- i_icmp_req  in  1  ICMP requests the port
- i_icmp_len  in  16  ICMP payload byte count, sampled at grant
- i_icmp_data  in  8  ICMP payload byte
- i_icmp_last  in  1  last ICMP byte
- i_icmp_valid  in  1  ICMP byte valid
- o_icmp_grant  out  1  ICMP owns the port
- o_send_data  out  8  to IP transmit data
- o_send_type  out  8  protocol number: 17 for UDP, 1 for ICMP
- o_send_len  out  16  payload length (the IP layer adds its 20-byte header)
- o_send_last  out  1  last byte to IP transmit
- o_send_valid  out  1  byte valid to IP transmit
- i_mac_last  in  1  end-of-frame pulse from the IP transmitter's mac output
- o_busy  out  1  state is not IDLE
- o_err  out  1  one-cycle pulse on any protocol error

Behaviour:
- Reset: all outputs 0; state IDLE; last-served = ICMP, so UDP wins the first tie.
- States: IDLE, GRANT, XFER, WAIT_DONE, GAP.
- IDLE:
  - With a single request, grant that requester.
  - With both requesting, grant the requester that is not last-served.
  - Next cycle: grant=1, len latched, type latched, last-served updated, go to GRANT.
- GRANT:
  - Owner's first valid byte goes to XFER.
  - If no valid arrives within P_GRANT_TIMEOUT cycles: drop grant, pulse o_err, go to GAP.
- XFER:
  - Each owner valid byte is registered to the o_send_* outputs with 1 cycle latency.
  - o_send_type and o_send_len stay constant for the whole frame.
  - Byte counter is 16 bits, starts at 1 on the first byte.
  - The frame ends on the byte where owner last=1 OR counter==len; that byte carries o_send_last=1.
  - Mismatch (last before len, or count reaches len without last) pulses o_err on the closing byte.
  - Bytes after the close are dropped.
  - Grant deasserts the cycle after the closing byte is accepted; go to WAIT_DONE.
- Gaps in owner valid during XFER are forwarded as gaps; no timeout applies in XFER.
- Non-owner valid in any state is ignored and pulses o_err. Non-owner req stays pending.
- len==0 at grant is treated as len 65536. It is not a frame error by itself; last terminates.
- WAIT_DONE: i_mac_last goes to GAP. If it does not arrive within P_DONE_TIMEOUT cycles: pulse o_err, go to GAP.
- i_mac_last outside WAIT_DONE is ignored.
- GAP: count P_GAP_CYCLES cycles, then go to IDLE. Arbitration resumes in IDLE, so the minimum request-to-grant time is 1 cycle.
- o_send_valid and o_send_last are 0 outside XFER, plus the 1-cycle drain.
- Requests dropping before grant are honoured (nothing granted). A request dropping after grant does not affect the transfer.
- Mid-operation reset: next cycle all outputs 0, state IDLE, counters cleared, no partial frame continued.

Test Plan:
- UDP-only frame: UDP req, len=10, 10 bytes 0x00..0x09 with last on the 10th → o_udp_grant=1; o_send_type=17, o_send_len=10; bytes appear 1 cycle later with o_send_last on 0x09; no o_err; next grant only after i_mac_last plus 8 idle cycles.
- Simultaneous requests after reset: both req, each len=4, repeated 4 times → grants alternate UDP, ICMP, UDP, ICMP…; ICMP frames show o_send_type=1.
- Length mismatch: UDP len=8, last on byte 5 → o_send_last on byte 5, o_err one pulse. Then UDP len=4 with 6 bytes and no last → o_send_last on byte 4, bytes 5-6 dropped, o_err pulse.
- Grant timeout: ICMP req granted, no valid for 64 cycles → grant drops at cycle 64, o_err pulse; a pending UDP req is granted after 8 gap cycles.
- Done timeout and stray inputs: frame completes but i_mac_last is never sent → o_err after 2048 cycles, then IDLE. Non-owner valid during XFER → o_err pulse, output stream unchanged.
- Reset mid-XFER: i_rst asserted on byte 3 of 10 → all outputs 0 next cycle; a new request afterwards gets a fresh grant with correct len and type.
